// File: rtl/n64_pkg.sv
// Shared N64 controller definitions: poller FSM states, poll command,
// status-word bit positions used by the arbiter, and protocol timings.
package n64_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_BIT,
    ST_TX_STOP,
    ST_RX_WAIT,
    ST_RX_BIT,
    ST_RX_STOP,
    ST_DONE,
    ST_FAIL
  } n64_state_t;

  localparam logic [7:0] POLL_CMD = 8'h01;

  localparam int BIT_A     = 29;
  localparam int BIT_B     = 28;
  localparam int BIT_Z     = 27;
  localparam int BIT_START = 26;
  localparam int BIT_DU    = 25;
  localparam int BIT_DD    = 24;
  localparam int BIT_DL    = 23;
  localparam int BIT_DR    = 22;
  localparam int BIT_L     = 21;
  localparam int BIT_R     = 20;
  localparam int BIT_CU    = 19;
  localparam int BIT_CD    = 18;
  localparam int BIT_CL    = 17;
  localparam int BIT_CR    = 16;
  localparam int JOYX_MSB  = 15;
  localparam int JOYX_LSB  = 8;
  localparam int JOYY_MSB  = 7;
  localparam int JOYY_LSB  = 0;

  localparam int T_1US = 1;
  localparam int T_2US = 2;
  localparam int T_3US = 3;
  localparam int T_4US = 4;
  localparam int T_6US = 6;

  // Raw bits 23:22 (reset/reserved) are not part of the status word.
  function automatic logic [29:0] raw_to_status(input logic [31:0] raw);
    return {raw[31:24], raw[21:0]};
  endfunction

endpackage

// File: rtl/n64_poller_if.sv
// Poller-facing bus: pad signals, status word to the arbiter, and FSM debug state.
// status_valid is a one-cycle strobe with no back-pressure; status is stable while it is high and holds afterwards.
interface n64_poller_if;
  import n64_pkg::*;

  logic        data_in;
  logic        data_oe;
  logic [29:0] status;
  logic        status_valid;
  logic        present;
  n64_state_t  state;

  modport master (input data_in, output data_oe, status, status_valid, present, state);
  modport slave  (output data_in, input data_oe, status, status_valid, present, state);

endinterface

// File: rtl/n64_line_sync.sv
// Two-flop synchronizer for the asynchronous data pad plus a falling-edge strobe.
module n64_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic data_in,
  output logic line,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Reset to the idle-high level so release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= data_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign line = sync;
  assign fall = prev & ~sync;

endmodule

// File: rtl/n64_poller.sv
// N64 controller poller: periodically sends the 0x01 poll command on the open-drain
// line, receives the 32-bit reply and publishes it as the 30-bit status word.
module n64_poller
  import n64_pkg::*;
#(
  parameter int CLK_PER_US  = 27,
  parameter int POLL_CYCLES = 405000,
  parameter int RX_TIMEOUT  = 200
) (
  input  logic          clk,
  input  logic          rst_n,
  n64_poller_if.master  bus
);

  localparam int BW        = $clog2(T_6US * CLK_PER_US + 1);
  localparam int RX_TO_CYC = RX_TIMEOUT * CLK_PER_US;
  localparam int LONG_MAX  = (POLL_CYCLES > RX_TO_CYC) ? POLL_CYCLES : RX_TO_CYC;
  localparam int LW        = $clog2(LONG_MAX + 1);

  localparam logic [BW-1:0] US1_LAST  = BW'(T_1US * CLK_PER_US - 1);
  localparam logic [BW-1:0] US3_LAST  = BW'(T_3US * CLK_PER_US - 1);
  localparam logic [BW-1:0] CELL_LAST = BW'(T_4US * CLK_PER_US - 1);
  localparam logic [BW-1:0] US2       = BW'(T_2US * CLK_PER_US);
  localparam logic [BW-1:0] US4       = BW'(T_4US * CLK_PER_US);
  localparam logic [BW-1:0] US6       = BW'(T_6US * CLK_PER_US);
  localparam logic [LW-1:0] POLL_LAST  = LW'(POLL_CYCLES - 1);
  localparam logic [LW-1:0] RX_TO_LAST = LW'(RX_TO_CYC - 1);

  n64_state_t  state;
  logic [BW-1:0] bit_tmr;
  logic [LW-1:0] long_tmr;
  logic [2:0]  tx_idx;
  logic [4:0]  rx_idx;
  logic        sampled;
  logic [31:0] raw;
  logic        data_oe;
  logic [29:0] status;
  logic        status_valid;
  logic        present;
  logic        line;
  logic        fall;
  logic [BW-1:0] tx_low_last;

  n64_line_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (bus.data_in),
    .line    (line),
    .fall    (fall)
  );

  assign tx_low_last = POLL_CMD[tx_idx] ? US1_LAST : US3_LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bit_tmr      <= '0;
      long_tmr     <= '0;
      tx_idx       <= '0;
      rx_idx       <= '0;
      sampled      <= 1'b0;
      raw          <= '0;
      data_oe      <= 1'b0;
      status       <= '0;
      status_valid <= 1'b0;
      present      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (long_tmr == POLL_LAST) begin
            state    <= ST_TX_BIT;
            long_tmr <= '0;
            bit_tmr  <= '0;
            tx_idx   <= 3'd7;
            data_oe  <= 1'b1;
          end else begin
            long_tmr <= long_tmr + 1'b1;
          end
        end
        ST_TX_BIT: begin
          if (bit_tmr == CELL_LAST) begin
            bit_tmr <= '0;
            data_oe <= 1'b1;
            if (tx_idx == 3'd0) state <= ST_TX_STOP;
            else tx_idx <= tx_idx - 1'b1;
          end else begin
            if (bit_tmr == tx_low_last) data_oe <= 1'b0;
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
        ST_TX_STOP: begin
          // The stop bit's high phase overlaps the reply wait.
          if (bit_tmr == US1_LAST) begin
            data_oe  <= 1'b0;
            state    <= ST_RX_WAIT;
            long_tmr <= '0;
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
        ST_RX_WAIT: begin
          if (fall) begin
            state   <= ST_RX_BIT;
            rx_idx  <= 5'd31;
            bit_tmr <= BW'(1);
            sampled <= 1'b0;
          end else if (long_tmr == RX_TO_LAST) begin
            state   <= ST_FAIL;
            status  <= '0;
            present <= 1'b0;
          end else begin
            long_tmr <= long_tmr + 1'b1;
          end
        end
        ST_RX_BIT: begin
          // Edges before the sample point are noise and never restart the cell.
          if (sampled && fall) begin
            rx_idx  <= rx_idx - 1'b1;
            bit_tmr <= BW'(1);
            sampled <= 1'b0;
          end else if (bit_tmr == US6) begin
            state   <= ST_FAIL;
            status  <= '0;
            present <= 1'b0;
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
            if (!sampled && bit_tmr == US2) begin
              raw     <= {raw[30:0], line};
              sampled <= 1'b1;
              if (rx_idx == 5'd0) begin
                state   <= ST_RX_STOP;
                bit_tmr <= '0;
              end
            end
          end
        end
        ST_RX_STOP: begin
          if (line) begin
            state        <= ST_DONE;
            status       <= raw_to_status(raw);
            status_valid <= 1'b1;
            present      <= 1'b1;
          end else if (bit_tmr == US4) begin
            state   <= ST_FAIL;
            status  <= '0;
            present <= 1'b0;
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
        ST_DONE: begin
          status_valid <= 1'b0;
          state        <= ST_IDLE;
          long_tmr     <= '0;
        end
        ST_FAIL: begin
          state    <= ST_IDLE;
          long_tmr <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.data_oe      = data_oe;
  assign bus.status       = status;
  assign bus.status_valid = status_valid;
  assign bus.present      = present;
  assign bus.state        = state;

endmodule

// File: tb/tb_n64_poller.sv
// Bench for n64_poller: an open-drain controller model replies to polls; a scoreboard
// checks every status strobe and every command low-pulse width.
module tb_n64_poller;
  import n64_pkg::*;

  localparam int CPU  = 27;
  localparam int POLL = 2000;
  localparam int RXTO = 200;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic ctrl_oe = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [29:0] exp_q[$];
  int          tx_q[$];

  n64_poller_if bus ();

  // Open-drain wire with pull-up: low whenever either side pulls.
  wire line_lvl = ~(bus.data_oe | ctrl_oe);
  assign bus.data_in = line_lvl;

  n64_poller #(
    .CLK_PER_US  (CPU),
    .POLL_CYCLES (POLL),
    .RX_TIMEOUT  (RXTO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Status scoreboard monitor.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (bus.status_valid) begin
      check("valid_single_pulse", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=0x%0h required=no strobe", bus.status);
      end else begin
        logic [29:0] e;
        e = exp_q.pop_front();
        check("status_word", {2'b00, bus.status}, {2'b00, e});
        check("present_on_valid", {31'd0, bus.present}, 32'd1);
      end
    end
    prev_valid = bus.status_valid;
  end

  // Command waveform monitor: width of each DataOE low pulse.
  int   oe_w    = 0;
  logic oe_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.data_oe) begin
      oe_w++;
    end else if (oe_prev) begin
      if (tx_q.size() > 0) begin
        int w;
        w = tx_q.pop_front();
        check("tx_low_width", oe_w, w);
      end
      oe_w = 0;
    end
    oe_prev = bus.data_oe;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_cmd_widths();
    for (int i = 0; i < 7; i++) tx_q.push_back(3 * CPU);
    tx_q.push_back(CPU);
    tx_q.push_back(CPU);
  endtask

  task automatic measure_poll(input string name);
    int n = 0;
    while (n < POLL + 100) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.data_oe) break;
    end
    check(name, n, POLL);
  endtask

  // Returns just after the stop-bit release of the poll command.
  task automatic wait_cmd();
    int   n     = 0;
    int   falls = 0;
    logic p     = bus.data_oe;
    while (n < 6000 && falls < 9) begin
      @(posedge clk);
      #1;
      n++;
      if (p && !bus.data_oe) falls++;
      p = bus.data_oe;
    end
    check("cmd_pulses", falls, 9);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ctrl_oe = 1'b1;
    wait_cycles(b ? CPU : 3 * CPU);
    ctrl_oe = 1'b0;
    if (glitch) begin
      wait_cycles(1);
      ctrl_oe = 1'b1;
      wait_cycles(3);
      ctrl_oe = 1'b0;
      wait_cycles(3 * CPU - 4);
    end else begin
      wait_cycles(b ? 3 * CPU : CPU);
    end
  endtask

  task automatic reply(input logic [31:0] word, input int nbits, input int glitch_at);
    logic [31:0] w;
    w = word;
    wait_cycles(2 * CPU);
    for (int i = 0; i < nbits; i++) send_bit(w[31 - i], i == glitch_at);
    if (nbits == 32) begin
      ctrl_oe = 1'b1;
      wait_cycles(2 * CPU);
      ctrl_oe = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("status_strobe_seen", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    // Reset state.
    wait_cycles(3);
    check("rst_data_oe", {31'd0, bus.data_oe}, 32'd0);
    check("rst_status", {2'b00, bus.status}, 32'd0);
    check("rst_valid", {31'd0, bus.status_valid}, 32'd0);
    check("rst_present", {31'd0, bus.present}, 32'd0);
    check("rst_state", {29'd0, bus.state}, {29'd0, ST_IDLE});

    // 1: good reply, full command waveform.
    push_cmd_widths();
    exp_q.push_back(30'h2000_8050);
    @(negedge clk);
    rst_n = 1'b1;
    measure_poll("first_poll_latency");
    wait_cmd();
    reply(32'h8000_8050, 32, -1);
    wait_drain();
    check("t1_present", {31'd0, bus.present}, 32'd1);

    // 2: no reply -> timeout 200 us after the stop release, status cleared.
    wait_cmd();
    n = 0;
    while (bus.status != 30'd0 && n < 6000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rx_timeout_cycles", n, RXTO * CPU);
    check("t2_present", {31'd0, bus.present}, 32'd0);
    // One FAIL cycle, then POLL cycles of IDLE.
    n = 0;
    while (!bus.data_oe && n < POLL + 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("repoll_after_fail", n, POLL + 1);

    // 3: good reply, then a reply truncated after 20 bits.
    exp_q.push_back(30'h04B4_5678);
    wait_cmd();
    reply(32'h1234_5678, 32, -1);
    wait_drain();
    check("t3_status_before", {2'b00, bus.status}, 32'h04B4_5678);
    wait_cmd();
    reply(32'hFFFF_FFFF, 19, -1);
    ctrl_oe = 1'b1;
    n = 0;
    while (bus.status != 30'd0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (n == CPU) ctrl_oe = 1'b0;
    end
    ctrl_oe = 1'b0;
    // 2-cycle sync, 1 cycle to accept the edge, then 6 us.
    check("trunc_fail_cycles", n, 3 + 6 * CPU);
    check("t3_present", {31'd0, bus.present}, 32'd0);

    // 4: reserved bits set, DU and DR set.
    push_cmd_widths();
    exp_q.push_back(30'h0240_1234);
    wait_cmd();
    reply(32'h09C0_1234, 32, -1);
    wait_drain();
    check("t4_du", {31'd0, bus.status[BIT_DU]}, 32'd1);
    check("t4_dl_dr", {30'd0, bus.status[BIT_DL:BIT_DR]}, 32'd1);

    // 6: glitch 1 us into a '1' bit must not disturb sampling or the bit count.
    exp_q.push_back(30'h2965_F00F);
    wait_cmd();
    reply(32'hA5A5_F00F, 32, 8);
    wait_drain();

    // 5a: reset mid-RX_BIT.
    wait_cmd();
    wait_cycles(2 * CPU);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    ctrl_oe = 1'b1;
    wait_cycles(10);
    #3;
    rst_n = 1'b0;
    #1;
    check("rx_rst_data_oe", {31'd0, bus.data_oe}, 32'd0);
    check("rx_rst_status", {2'b00, bus.status}, 32'd0);
    check("rx_rst_valid", {31'd0, bus.status_valid}, 32'd0);
    check("rx_rst_present", {31'd0, bus.present}, 32'd0);
    ctrl_oe = 1'b0;
    wait_cycles(4);
    @(negedge clk);
    rst_n = 1'b1;
    measure_poll("poll_after_rx_reset");

    // 5b: reset while DataOE is driving low in TX_BIT.
    wait_cycles(10);
    check("tx_oe_before_reset", {31'd0, bus.data_oe}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("tx_rst_data_oe", {31'd0, bus.data_oe}, 32'd0);
    check("tx_rst_state", {29'd0, bus.state}, {29'd0, ST_IDLE});
    wait_cycles(4);
    push_cmd_widths();
    exp_q.push_back(30'h2000_8050);
    @(negedge clk);
    rst_n = 1'b1;
    measure_poll("poll_after_tx_reset");
    wait_cmd();
    reply(32'h8000_8050, 32, -1);
    wait_drain();

    check("tx_queue_empty", tx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
